// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file port arbiter.
package rf_arb_pkg;

    localparam int unsigned RF_DATA_W = 16;
    localparam int unsigned RF_SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } rf_arb_state_t;

    // One requester's access: direction, register index and write data
    typedef struct packed {
        logic                 we;
        logic [RF_SEL_W-1:0]  addr;
        logic [RF_DATA_W-1:0] wdata;
    } rf_txn_t;

    // Index width for n requesters, never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping mod N.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]        req,
    input  logic [idx_w(N)-1:0] rr_ptr,
    output logic [N-1:0]        win_oh_c,
    output logic [idx_w(N)-1:0] win_idx_c,
    output logic                any_req_c
);

    localparam int unsigned IW = idx_w(N);
    localparam int unsigned SW = IW + 1;

    logic [SW-1:0] cand;
    logic          found;

    // One spare bit holds rr_ptr + k before the modulo-N fold
    always_comb begin
        win_oh_c  = '0;
        win_idx_c = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = SW'(rr_ptr) + SW'(k);
            if (cand >= SW'(N)) begin
                cand = cand - SW'(N);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found                   = 1'b1;
                win_oh_c[cand[IW-1:0]]  = 1'b1;
                win_idx_c               = cand[IW-1:0];
            end
        end
    end

    assign any_req_c = |req;

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter owning the 8x16 register-file access path; one read or write per grant.
// Optional back-to-back locked grants when RF_ARB_LOCK_EN is defined.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                         clock,
    input  logic                         reset_L,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           we,
    input  logic [NUM_REQ*RF_SEL_W-1:0]  addr,
    input  logic [NUM_REQ*RF_DATA_W-1:0] wdata,
`ifdef RF_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]           lock,
`endif
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           ack,
    output logic [RF_DATA_W-1:0]         rdata,
    output logic                         busy,
    input  logic [RF_DATA_W-1:0]         rf_outB,
    output logic [RF_SEL_W-1:0]          rf_selA,
    output logic [RF_SEL_W-1:0]          rf_selB,
    output logic [RF_DATA_W-1:0]         rf_in,
    output logic                         rf_load_L
);

    localparam int unsigned IW = idx_w(NUM_REQ);

    rf_arb_state_t        state_q, state_d;
    rf_txn_t              txn_q, txn_d;
    rf_txn_t              txn_a [NUM_REQ];
    logic [IW-1:0]        win_q, win_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   gnt_d, ack_d;
    logic [RF_DATA_W-1:0] rdata_d;
    logic                 load_q, load_d;
    logic [NUM_REQ-1:0]   arb_oh_c;
    logic [IW-1:0]        arb_idx_c;
    logic                 arb_any_c;
    logic                 relock_c;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .win_oh_c  (arb_oh_c),
        .win_idx_c (arb_idx_c),
        .any_req_c (arb_any_c)
    );

    // Per-requester view of the flattened request buses
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            txn_a[i] = '{we:    we[i],
                         addr:  addr[i*RF_SEL_W +: RF_SEL_W],
                         wdata: wdata[i*RF_DATA_W +: RF_DATA_W]};
        end
    end

`ifdef RF_ARB_LOCK_EN
    assign relock_c = lock[win_q] & req[win_q];
`else
    assign relock_c = 1'b0;
`endif

    // Next state and next values of every registered output
    always_comb begin
        state_d  = state_q;
        txn_d    = txn_q;
        win_d    = win_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt;
        ack_d    = '0;
        rdata_d  = rdata;
        unique case (state_q)
            IDLE: begin
                if (arb_any_c) begin
                    state_d = ACCESS;
                    gnt_d   = arb_oh_c;
                    win_d   = arb_idx_c;
                    txn_d   = txn_a[arb_idx_c];
                end
            end
            ACCESS: begin
                state_d = DONE;
                ack_d   = gnt;
                if (!txn_q.we) begin
                    rdata_d = rf_outB;
                end
            end
            DONE: begin
                if (relock_c) begin
                    state_d = ACCESS;
                    txn_d   = txn_a[win_q];
                end else begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        load_d = (state_d == ACCESS) && txn_d.we;
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q  <= IDLE;
            txn_q    <= '0;
            win_q    <= '0;
            rr_ptr_q <= '0;
            gnt      <= '0;
            ack      <= '0;
            rdata    <= '0;
            load_q   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            txn_q    <= txn_d;
            win_q    <= win_d;
            rr_ptr_q <= rr_ptr_d;
            gnt      <= gnt_d;
            ack      <= ack_d;
            rdata    <= rdata_d;
            load_q   <= load_d;
            busy     <= (state_d != IDLE);
        end
    end

    // Selects and data follow the latched fields; reset suppresses a write already in flight
    assign rf_selA   = txn_q.addr;
    assign rf_selB   = txn_q.addr;
    assign rf_in     = txn_q.wdata;
    assign rf_load_L = ~(load_q & reset_L);

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural 8x16 register file.
module tb_rf_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_L;
    logic [1:0]  req, we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  gnt, ack;
    logic [15:0] rdata, rf_outB, rf_in;
    logic        busy, rf_load_L;
    logic [2:0]  rf_selA, rf_selB;
`ifdef RF_ARB_LOCK_EN
    logic [1:0]  lock;
    logic [2:0]  lock3;
`endif

    logic [2:0]  req3, we3, gnt3, ack3;
    logic [8:0]  addr3;
    logic [47:0] wdata3;
    logic [15:0] rdata3, in3;
    logic [15:0] outb3 = 16'h0;
    logic        busy3, load3_L;
    logic [2:0]  sela3, selb3;

    logic [15:0] rf_mem [8] = '{default: 16'h0};
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (!rf_load_L) rf_mem[rf_selA] <= rf_in;
    assign rf_outB = rf_mem[rf_selB];

    rf_port_arbiter #(.NUM_REQ(2)) u_dut (
        .clock(clock), .reset_L(reset_L), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef RF_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .rf_outB(rf_outB),
        .rf_selA(rf_selA), .rf_selB(rf_selB), .rf_in(rf_in), .rf_load_L(rf_load_L)
    );

    rf_port_arbiter #(.NUM_REQ(3)) u_dut3 (
        .clock(clock), .reset_L(reset_L), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
`ifdef RF_ARB_LOCK_EN
        .lock(lock3),
`endif
        .gnt(gnt3), .ack(ack3), .rdata(rdata3), .busy(busy3), .rf_outB(outb3),
        .rf_selA(sela3), .rf_selB(selb3), .rf_in(in3), .rf_load_L(load3_L)
    );

    typedef struct {
        int          id;
        logic        w;
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_L = 1'b0;
        req = '0; we = '0; req3 = '0; we3 = '0;
`ifdef RF_ARB_LOCK_EN
        lock = '0; lock3 = '0;
`endif
        @(negedge clock);
        reset_L = 1'b1;
    endtask

    // Single transaction from requester id; checks grant, load strobe, latency and read data
    task automatic do_txn(input int id, input logic w, input logic [2:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input string tag);
        int         lat;
        logic [1:0] oh;
        oh = 2'(2'b01 << id);
        @(negedge clock);
        req[id] = 1'b1;
        we[id]  = w;
        addr[id*3 +: 3]   = a;
        wdata[id*16 +: 16] = d;
        lat = 0;
        while (ack[id] !== 1'b1 && lat < 10) begin
            @(negedge clock);
            lat++;
            if (lat == 1) begin
                check({tag, ".gnt"}, 32'(gnt), 32'(oh));
                check({tag, ".load_L"}, 32'(rf_load_L), 32'(!w));
                check({tag, ".selA"}, 32'(rf_selA), 32'(a));
            end
            if (lat == 2) check({tag, ".load_L_off"}, 32'(rf_load_L), 32'd1);
        end
        req[id] = 1'b0;
        check({tag, ".lat"}, 32'(lat), 32'd2);
        check({tag, ".ack"}, 32'(ack), 32'(oh));
        if (!w) check({tag, ".rdata"}, 32'(rdata), 32'(exp_rd));
    endtask

    initial begin
        logic [1:0]  acks [4];
        logic [15:0] rds [4];
        int          cycs [8];
        int          ids [8];
        logic [2:0]  acks3 [3];
        int          nseen, guard, k, nev;
        logic        got1;
        logic [15:0] rd1;

        tbl[0] = '{0, 1'b1, 3'd5, 16'hBEEF, 16'h0000};
        tbl[1] = '{0, 1'b0, 3'd5, 16'h0000, 16'hBEEF};
        tbl[2] = '{1, 1'b1, 3'd0, 16'h1357, 16'h0000};
        tbl[3] = '{1, 1'b1, 3'd7, 16'hFFFF, 16'h0000};
        tbl[4] = '{0, 1'b0, 3'd0, 16'h0000, 16'h1357};
        tbl[5] = '{1, 1'b0, 3'd7, 16'h0000, 16'hFFFF};
        tbl[6] = '{0, 1'b1, 3'd7, 16'hA5A5, 16'h0000};
        tbl[7] = '{1, 1'b0, 3'd7, 16'h0000, 16'hA5A5};
        tbl[8] = '{1, 1'b0, 3'd3, 16'h0000, 16'h0000};

        reset_L = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
`ifdef RF_ARB_LOCK_EN
        lock = '0; lock3 = '0;
`endif

        // Reset state
        repeat (2) @(negedge clock);
        check("rst.gnt", 32'(gnt), 32'd0);
        check("rst.ack", 32'(ack), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.load_L", 32'(rf_load_L), 32'd1);
        check("rst.rdata", 32'(rdata), 32'd0);
        check("rst.gnt3", 32'(gnt3), 32'd0);
        reset_L = 1'b1;
        @(negedge clock);
        check("rst.idle_busy", 32'(busy), 32'd0);

        // Table of single transactions
        for (int i = 0; i < 9; i++) begin
            do_txn(tbl[i].id, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd, $sformatf("vec%0d", i));
        end

        // Round robin with both requesters held
        apply_reset();
        @(negedge clock);
        req = 2'b11; we = 2'b00; addr = {3'd0, 3'd5};
        nseen = 0; guard = 0;
        while (nseen < 4 && guard < 40) begin
            @(negedge clock);
            guard++;
            if (ack != 2'b00) begin
                acks[nseen] = ack; rds[nseen] = rdata; cycs[nseen] = cyc;
                nseen++;
                if (nseen == 4) req = 2'b00;
            end
        end
        check("rr.count", 32'(nseen), 32'd4);
        if (nseen == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr.ack%0d", i), 32'(acks[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
                check($sformatf("rr.rdata%0d", i), 32'(rds[i]), (i % 2 == 0) ? 32'hBEEF : 32'h1357);
                if (i > 0) check($sformatf("rr.gap%0d", i), 32'(cycs[i] - cycs[i-1]), 32'd3);
            end
        end

        // Reset asserted in the ACCESS cycle of a write
        @(negedge clock);
        req[0] = 1'b1; we[0] = 1'b1; addr[2:0] = 3'd3; wdata[15:0] = 16'h1234;
        @(negedge clock);
        check("rstmid.busy_access", 32'(busy), 32'd1);
        reset_L = 1'b0; req = '0;
        #1 check("rstmid.load_L", 32'(rf_load_L), 32'd1);
        @(negedge clock);
        reset_L = 1'b1;
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.ack", 32'(ack), 32'd0);
        check("rstmid.gnt", 32'(gnt), 32'd0);
        check("rstmid.r3", 32'(rf_mem[3]), 32'd0);
        @(negedge clock);
        check("rstmid.ack_late", 32'(ack), 32'd0);
        do_txn(0, 1'b0, 3'd3, 16'h0, 16'h0000, "rstmid.rd");

        // Locked back-to-back writes from requester 0 with requester 1 pending
        apply_reset();
        @(negedge clock);
        req = 2'b11; we = 2'b01; addr = {3'd2, 3'd1}; wdata = {16'h0000, 16'h1111};
`ifdef RF_ARB_LOCK_EN
        lock = 2'b01;
`endif
        k = 0; got1 = 1'b0; guard = 0; nev = 0; rd1 = 16'hDEAD;
        while ((k < 3 || !got1) && guard < 40) begin
            @(negedge clock);
            guard++;
            if (ack[0] && nev < 8) begin
                ids[nev] = 0; cycs[nev] = cyc; nev++; k++;
                if (k == 1) begin
                    addr[2:0] = 3'd2; wdata[15:0] = 16'h2222;
                end else if (k == 2) begin
                    addr[2:0] = 3'd4; wdata[15:0] = 16'h4444;
                end else begin
                    req[0] = 1'b0;
`ifdef RF_ARB_LOCK_EN
                    lock[0] = 1'b0;
`endif
                end
            end
            if (ack[1] && nev < 8) begin
                ids[nev] = 1; cycs[nev] = cyc; nev++;
                got1 = 1'b1; req[1] = 1'b0; rd1 = rdata;
            end
        end
        check("lock.events", 32'(nev), 32'd4);
        if (nev == 4) begin
            for (int i = 0; i < 4; i++) begin
`ifdef RF_ARB_LOCK_EN
                check($sformatf("lock.id%0d", i), 32'(ids[i]), (i == 3) ? 32'd1 : 32'd0);
                check($sformatf("lock.t%0d", i), 32'(cycs[i] - cycs[0]), (i == 3) ? 32'd7 : 32'(2 * i));
`else
                check($sformatf("lock.id%0d", i), 32'(ids[i]), (i == 1) ? 32'd1 : 32'd0);
                check($sformatf("lock.t%0d", i), 32'(cycs[i] - cycs[0]), 32'(3 * i));
`endif
            end
        end
`ifdef RF_ARB_LOCK_EN
        check("lock.rd1", 32'(rd1), 32'h2222);
`else
        check("lock.rd1", 32'(rd1), 32'h0000);
`endif
        check("lock.r1", 32'(rf_mem[1]), 32'h1111);
        check("lock.r2", 32'(rf_mem[2]), 32'h2222);
        check("lock.r4", 32'(rf_mem[4]), 32'h4444);

        // Three requesters: pointer wraps after requester 2
        apply_reset();
        @(negedge clock);
        req3 = 3'b100;
        nseen = 0; guard = 0;
        while (nseen < 3 && guard < 40) begin
            @(negedge clock);
            guard++;
            if (ack3 != 3'b000) begin
                acks3[nseen] = ack3; nseen++;
                if (ack3[2]) req3 = 3'b011;
                else req3 = req3 & ~ack3;
            end
        end
        check("wrap.count", 32'(nseen), 32'd3);
        if (nseen == 3) begin
            check("wrap.ack0", 32'(acks3[0]), 32'b100);
            check("wrap.ack1", 32'(acks3[1]), 32'b001);
            check("wrap.ack2", 32'(acks3[2]), 32'b010);
        end

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
